// File: rtl/bs_feed_pkg.sv
// Shared types and constants for the bitstream feed controller.
package bs_feed_pkg;

  localparam int STATE_W    = 3;
  localparam int DW_DEFAULT = 16;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    DEC_RST = 3'd1,
    STREAM  = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } bs_feed_state_e;

endpackage

// File: rtl/bs_feed_fifo.sv
// Synchronous FIFO; accepts a push while full if a pop happens in the same cycle.
module bs_feed_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DW-1:0]          wdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [DW-1:0]          head
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign level   = count;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bs_feed_ctrl.sv
// Host-to-decoder bitstream feeder: toggle handshake, pending slot, FIFO, decoder sequencing.
// Optional word/drop statistics ports when BS_FEED_STATS_EN is defined.
module bs_feed_ctrl
  import bs_feed_pkg::*;
#(
  parameter int DW         = DW_DEFAULT,
  parameter int DEPTH      = 8,
  parameter int RST_CYCLES = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n,
  input  logic [DW-1:0]          host_data_i,
  input  logic [1:0]             host_ctrl_i,
  output logic                   host_ack_o,
  output logic [STATE_W-1:0]     host_state_o,
  output logic [$clog2(DEPTH):0] fifo_level_o,
  output logic                   dec_rst_n_o,
  output logic [DW-1:0]          dec_data_o,
  output logic                   dec_valid_o,
  input  logic                   dec_ready_i,
  output logic                   dec_eos_o,
  input  logic                   dec_idle_i
`ifdef BS_FEED_STATS_EN
  ,
  output logic [15:0]            stat_words_o,
  output logic                   stat_drop_o
`endif
);

  localparam int CW = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);

  bs_feed_state_e state, state_nx;

  logic [1:0]    ctrl_q;
  logic [DW-1:0] data_q;
  logic          tog_prev;
  logic          wr_evt;
  logic [CW-1:0] rst_cnt;
  logic          pend_valid;
  logic [DW-1:0] pend_data;
  logic          accept;
  logic          drop;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;

  assign wr_evt    = ctrl_q[0] ^ tog_prev;
  assign accept    = wr_evt && (state == STREAM) && !pend_valid;
  assign drop      = wr_evt && (state == STREAM) && pend_valid;
  assign fifo_pop  = !fifo_empty && dec_ready_i;
  assign fifo_push = pend_valid && (!fifo_full || fifo_pop);

  assign dec_valid_o  = !fifo_empty;
  assign host_state_o = state;

  // Reset loads the toggle history from the live input so no write is seen on release.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      ctrl_q   <= host_ctrl_i;
      tog_prev <= host_ctrl_i[0];
      data_q   <= '0;
    end else begin
      ctrl_q   <= host_ctrl_i;
      tog_prev <= ctrl_q[0];
      data_q   <= host_data_i;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      host_ack_o <= 1'b0;
    end else begin
      if (fifo_push) begin
        pend_valid <= 1'b0;
        host_ack_o <= ~host_ack_o;
      end
      if (accept) begin
        pend_valid <= 1'b1;
        pend_data  <= data_q;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state   <= IDLE;
      rst_cnt <= '0;
    end else begin
      state   <= state_nx;
      rst_cnt <= (state == DEC_RST) ? rst_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nx    = state;
    dec_eos_o   = 1'b0;
    dec_rst_n_o = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_q[1]) state_nx = DEC_RST;
      end
      DEC_RST: begin
        if (!ctrl_q[1])               state_nx = IDLE;
        else if (rst_cnt == RST_LAST) state_nx = STREAM;
      end
      STREAM: begin
        dec_rst_n_o = 1'b1;
        if (!ctrl_q[1]) state_nx = DRAIN;
      end
      DRAIN: begin
        dec_rst_n_o = 1'b1;
        if (fifo_empty && !pend_valid) begin
          dec_eos_o = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE: begin
        dec_rst_n_o = 1'b1;
        if (dec_idle_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  bs_feed_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (pend_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level_o),
    .head  (dec_data_o)
  );

`ifdef BS_FEED_STATS_EN
  logic stat_clr;
  assign stat_clr = (state == IDLE) && (state_nx == DEC_RST);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n || stat_clr) begin
      stat_words_o <= '0;
      stat_drop_o  <= 1'b0;
    end else begin
      if (fifo_pop && (stat_words_o != '1)) stat_words_o <= stat_words_o + 1'b1;
      if (drop) stat_drop_o <= 1'b1;
    end
  end
`endif

endmodule
